// File: rtl/branch_offset_encoder_pkg.sv
// Shared branch-encoding constants, instruction field layout and packing helper.
// Used by the branch offset encoder and any future branch/jump patch logic.
package branch_offset_encoder_pkg;

  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  localparam int BR_OFF_MIN = -(2 ** 17);
  localparam int BR_OFF_MAX = (2 ** 17) - 4;

  localparam int OPC_LSB = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
  } br_fields_t;

  function automatic logic [31:0] pack_branch(input br_fields_t f, input logic [15:0] imm_field);
    logic [31:0] w;
    w = '0;
    w[OPC_LSB +: 6] = f.opcode;
    w[RS_LSB  +: 5] = f.rs;
    w[RT_LSB  +: 5] = f.rt;
    w[15:0]         = imm_field;
    return w;
  endfunction

endpackage

// File: rtl/branch_offset_check.sv
// Combinational split of a 33-bit byte delta into the 16-bit word offset field
// plus alignment and reach errors; no latency, no handshake.
module branch_offset_check (
  input  logic [32:0] delta,
  output logic [15:0] imm,
  output logic        err_align,
  output logic        err_range
);

  assign imm       = delta[17:2];
  assign err_align = |delta[1:0];
  // In reach only when everything above the field is a pure sign extension.
  assign err_range = !((delta[32:17] == '0) || (delta[32:17] == '1));

endmodule

// File: rtl/branch_offset_encoder.sv
// Two-stage valid/ready encoder: (pc, target) -> branch word offset and packed instruction.
// Latency 2 cycles accept-to-out_valid; holds up to 2 beats, in_ready drops when both stages stall.
module branch_offset_encoder
  import branch_offset_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      pc,
  input  logic [31:0]      target,
  input  logic [5:0]       opcode,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic [15:0]      imm,
  output logic             err_align,
  output logic             err_range,
  output logic [CNT_W-1:0] err_count
);

  logic        s1_valid;
  logic [32:0] s1_delta;
  br_fields_t  s1_fields;

  logic        advance;
  logic        accept;
  logic        xfer;
  logic [15:0] chk_imm;
  logic        chk_align;
  logic        chk_range;

  assign advance  = !out_valid || out_ready;
  assign in_ready = !s1_valid || advance;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_delta  <= '0;
      s1_fields <= '0;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      // Zero-extended 33-bit subtract keeps the sign of a backward branch.
      s1_delta  <= {1'b0, target} - {1'b0, pc} - 33'd4;
      s1_fields <= {opcode, rs, rt};
    end else if (advance) begin
      s1_valid  <= 1'b0;
    end
  end

  branch_offset_check u_check (
    .delta     (s1_delta),
    .imm       (chk_imm),
    .err_align (chk_align),
    .err_range (chk_range)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      instr     <= '0;
      imm       <= '0;
      err_align <= 1'b0;
      err_range <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        imm       <= chk_imm;
        err_align <= chk_align;
        err_range <= chk_range;
        instr     <= pack_branch(s1_fields, (chk_align || chk_range) ? 16'h0000 : chk_imm);
      end
    end
  end

  // Errors are counted when the result leaves, so a stalled beat counts once.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (xfer && (err_align || err_range) && (err_count != '1)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule
